// File: rtl/pe_stream_ctrl_if.sv
// pe_stream_ctrl bus bundle: host control, buffer source and PE ports.
// master = controller side, slave = environment driving the controller.
interface pe_stream_ctrl_if #(
  parameter int DATA_SIZE    = 8,
  parameter int CONFIG_Q_BIT = 2,
  parameter int CONFIG_P_BIT = 5,
  parameter int CONFIG_U_BIT = 4,
  parameter int CONFIG_S_BIT = 4,
  parameter int CONFIG_F_BIT = 12,
  parameter int CONFIG_W_BIT = 12
) ();
  logic                    start;
  logic [CONFIG_Q_BIT-1:0] cfg_q;
  logic [CONFIG_P_BIT-1:0] cfg_p;
  logic [CONFIG_U_BIT-1:0] cfg_U;
  logic [CONFIG_S_BIT-1:0] cfg_S;
  logic [CONFIG_F_BIT-1:0] cfg_F;
  logic [CONFIG_W_BIT-1:0] cfg_W;

  logic [DATA_SIZE-1:0]    src_data;
  logic                    src_valid;
  logic                    src_ready;

  logic                    set_info;
  logic [CONFIG_Q_BIT-1:0] config_q;
  logic [CONFIG_P_BIT-1:0] config_p;
  logic [CONFIG_U_BIT-1:0] config_U;
  logic [CONFIG_S_BIT-1:0] config_S;
  logic [CONFIG_F_BIT-1:0] config_F;
  logic [CONFIG_W_BIT-1:0] config_W;

  logic [DATA_SIZE-1:0]    ifmap;
  logic                    ifmap_enable;
  logic                    ifmap_ready;
  logic                    opsum_enable;
  logic                    opsum_ready;

  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    input  start, cfg_q, cfg_p, cfg_U, cfg_S, cfg_F, cfg_W,
    input  src_data, src_valid, ifmap_ready, opsum_enable,
    output src_ready, set_info,
    output config_q, config_p, config_U, config_S, config_F, config_W,
    output ifmap, ifmap_enable, opsum_ready,
    output busy, done, err
  );

  modport slave (
    output start, cfg_q, cfg_p, cfg_U, cfg_S, cfg_F, cfg_W,
    output src_data, src_valid, ifmap_ready, opsum_enable,
    input  src_ready, set_info,
    input  config_q, config_p, config_U, config_S, config_F, config_W,
    input  ifmap, ifmap_enable, opsum_ready,
    input  busy, done, err
  );
endinterface

// File: rtl/pe_stream_ctrl.sv
// Per-PE sequencer: latch layer config, strobe it to the PE,
// stream W ifmap words in, collect F opsums, then pulse done.
module pe_stream_ctrl #(
  parameter int DATA_SIZE    = 8,
  parameter int CONFIG_Q_BIT = 2,
  parameter int CONFIG_P_BIT = 5,
  parameter int CONFIG_U_BIT = 4,
  parameter int CONFIG_S_BIT = 4,
  parameter int CONFIG_F_BIT = 12,
  parameter int CONFIG_W_BIT = 12
) (
  input logic         clk,
  input logic         rst,
  pe_stream_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CONFIG,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CONFIG_W_BIT-1:0] ONE_W = {{(CONFIG_W_BIT-1){1'b0}}, 1'b1};
  localparam logic [CONFIG_F_BIT-1:0] ONE_F = {{(CONFIG_F_BIT-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic [CONFIG_Q_BIT-1:0] cq;
  logic [CONFIG_P_BIT-1:0] cp;
  logic [CONFIG_U_BIT-1:0] cu;
  logic [CONFIG_S_BIT-1:0] cs;
  logic [CONFIG_F_BIT-1:0] cf;
  logic [CONFIG_W_BIT-1:0] cw;

  logic [CONFIG_W_BIT-1:0] ifm_cnt;
  logic [CONFIG_F_BIT-1:0] ops_cnt;
  logic                    err_q;

  logic                 cfg_ok;
  logic                 accept;
  logic                 ifm_xfer;
  logic                 ifm_last;
  logic                 ops_open;
  logic                 ops_xfer;
  logic                 ops_fin;

  logic                 set_info_c;
  logic                 ifmap_en_c;
  logic                 src_ready_c;
  logic                 done_c;
  logic [DATA_SIZE-1:0] ifmap_c;

  assign cfg_ok   = (bus.cfg_W != '0) && (bus.cfg_F != '0);
  assign accept   = (state == IDLE) && bus.start && cfg_ok;
  assign ifm_xfer = (state == STREAM) && bus.src_valid && bus.ifmap_ready;
  assign ifm_last = ifm_xfer && (ifm_cnt == cw - ONE_W);
  assign ops_open = ((state == STREAM) || (state == DRAIN)) && (ops_cnt < cf);
  assign ops_xfer = bus.opsum_enable && ops_open;
  assign ops_fin  = (ops_cnt == cf) || (ops_xfer && (ops_cnt == cf - ONE_F));

  // State register; reset aborts any pass without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state handshake outputs.
  always_comb begin
    state_nxt   = state;
    set_info_c  = 1'b0;
    ifmap_en_c  = 1'b0;
    src_ready_c = 1'b0;
    done_c      = 1'b0;
    ifmap_c     = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = CONFIG;
      end
      CONFIG: begin
        set_info_c = 1'b1;
        state_nxt  = STREAM;
      end
      STREAM: begin
        ifmap_c     = bus.src_data;
        ifmap_en_c  = bus.src_valid;
        src_ready_c = bus.ifmap_ready;
        if (ifm_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ops_fin) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, transfer counters and rejected-start strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cq      <= '0;
      cp      <= '0;
      cu      <= '0;
      cs      <= '0;
      cf      <= '0;
      cw      <= '0;
      ifm_cnt <= '0;
      ops_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && bus.start && !cfg_ok;
      if (accept) begin
        cq      <= bus.cfg_q;
        cp      <= bus.cfg_p;
        cu      <= bus.cfg_U;
        cs      <= bus.cfg_S;
        cf      <= bus.cfg_F;
        cw      <= bus.cfg_W;
        ifm_cnt <= '0;
        ops_cnt <= '0;
      end else begin
        if (ifm_xfer) ifm_cnt <= ifm_cnt + ONE_W;
        if (ops_xfer) ops_cnt <= ops_cnt + ONE_F;
      end
    end
  end

  assign bus.set_info     = set_info_c;
  assign bus.ifmap        = ifmap_c;
  assign bus.ifmap_enable = ifmap_en_c;
  assign bus.src_ready    = src_ready_c;
  assign bus.opsum_ready  = ops_open;
  assign bus.done         = done_c;
  assign bus.err          = err_q;
  assign bus.busy         = (state != IDLE);
  assign bus.config_q     = cq;
  assign bus.config_p     = cp;
  assign bus.config_U     = cu;
  assign bus.config_S     = cs;
  assign bus.config_F     = cf;
  assign bus.config_W     = cw;

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Self-checking bench for pe_stream_ctrl: directed passes plus
// randomized handshakes checked against a per-pass transaction model.
module tb_pe_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_stream_ctrl_if u ();

  pe_stream_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u.master)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] words[$];
  logic [7:0] got[$];
  int src_idx, cyc, set_cnt, set_cyc, done_cnt, done_cyc;
  int err_cnt, err_cyc, acks, last_ack, first_x, last_x;
  int leak, over, busy_hi, last_busy, cur_f;
  int exp_cfg, exp_w, exp_f;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got.delete();
    src_idx = 0; cyc = 0; set_cnt = 0; set_cyc = -1;
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    acks = 0; last_ack = -1; first_x = -1; last_x = -1;
    leak = 0; over = 0; busy_hi = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (u.ifmap_enable && u.ifmap_ready) begin
      got.push_back(u.ifmap);
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    if (u.src_valid && u.src_ready) src_idx++;
    if (u.src_ready && !u.ifmap_ready) leak++;
    if (u.opsum_ready && acks >= cur_f) over++;
    if (u.opsum_enable && u.opsum_ready) begin
      acks++;
      last_ack = cyc;
    end
    if (u.set_info) begin set_cnt++; set_cyc = cyc; end
    if (u.done) begin done_cnt++; done_cyc = cyc; end
    if (u.err) begin err_cnt++; err_cyc = cyc; end
    if (u.busy) busy_hi++;
    cyc++;
    @(posedge clk);
    #1;
    last_busy = int'(u.busy);
  endtask

  task automatic drive(input int w, input int rm, input int vm, input int om);
    u.src_valid = (vm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    u.src_data = (src_idx < words.size()) ? words[src_idx] : 8'($urandom);
    case (rm)
      0: u.ifmap_ready = 1'b1;
      1: u.ifmap_ready = (cyc % 2 == 0);
      default: u.ifmap_ready = 1'($urandom_range(0, 1));
    endcase
    case (om)
      0: u.opsum_enable = 1'b1;
      1: u.opsum_enable = 1'($urandom_range(0, 1));
      2: u.opsum_enable = (got.size() == w) && (cyc % 2 == 1);
      default: u.opsum_enable = 1'b0;
    endcase
  endtask

  task automatic set_cfg(input int w, input int f, input int q, input int p,
                         input int uu, input int s);
    u.cfg_W = 12'(w); u.cfg_F = 12'(f); u.cfg_q = 2'(q);
    u.cfg_p = 5'(p); u.cfg_U = 4'(uu); u.cfg_S = 4'(s);
  endtask

  function automatic int cfg_out();
    return int'({u.config_q, u.config_p, u.config_U, u.config_S});
  endfunction

  task automatic pass(input int w, input int f, input int q, input int p,
                      input int uu, input int s, input int rm, input int vm,
                      input int om, input bit bstart);
    int budget;
    words.delete();
    for (int i = 0; i < w; i++) words.push_back(8'($urandom));
    clr();
    cur_f = f;
    budget = 20 * w + 20 * f + 100;
    set_cfg(w, f, q, p, uu, s);
    exp_w = w; exp_f = f;
    exp_cfg = int'({2'(q), 5'(p), 4'(uu), 4'(s)});
    for (int n = 0; n < budget && done_cnt == 0; n++) begin
      u.start = (n == 0) || (bstart && cyc == 3);
      if (bstart && cyc == 3) set_cfg(w + 3, f + 1, q + 1, p + 1, uu + 1, s + 1);
      drive(w, rm, vm, om);
      tick();
      u.start = 1'b0;
    end
    u.src_valid = 1'b0;
    u.opsum_enable = 1'b0;
    tick();
  endtask

  task automatic check_pass(input string tag);
    int mism = 0;
    for (int i = 0; i < got.size() && i < words.size(); i++)
      if (got[i] !== words[i]) mism++;
    chk({tag, "_xfers"}, got.size(), exp_w);
    chk({tag, "_order"}, mism, 0);
    chk({tag, "_src_acc"}, src_idx, exp_w);
    chk({tag, "_acks"}, acks, exp_f);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_setinfo"}, set_cnt, 1);
    chk({tag, "_setcyc"}, set_cyc, 1);
    chk({tag, "_leak"}, leak, 0);
    chk({tag, "_over"}, over, 0);
    chk({tag, "_cfgW"}, int'(u.config_W), exp_w);
    chk({tag, "_cfgF"}, int'(u.config_F), exp_f);
    chk({tag, "_cfgqpus"}, cfg_out(), exp_cfg);
    chk({tag, "_busy_end"}, last_busy, 0);
    chk({tag, "_err"}, err_cnt, 0);
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, int'({u.busy, u.src_ready, u.ifmap_enable, u.opsum_ready,
                   u.set_info, u.done, u.err}), 0);
  endtask

  initial begin
    rst = 1'b1;
    u.start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    u.src_data = '0; u.src_valid = 1'b1;
    u.ifmap_ready = 1'b1; u.opsum_enable = 1'b1;
    cur_f = 0;
    clr();
    tick(); tick();
    outs_zero("reset_outs");
    chk("reset_cfg", int'({u.config_W, u.config_F}) | cfg_out(), 0);
    rst = 1'b0;
    u.opsum_enable = 1'b0;
    tick();

    pass(1, 1, 1, 2, 1, 3, 0, 0, 0, 1'b0);
    check_pass("min");
    chk("min_done_cyc", done_cyc, 4);

    pass(5, 3, 2, 9, 1, 3, 0, 0, 2, 1'b0);
    check_pass("basic");
    chk("basic_first_x", first_x, 2);
    chk("basic_last_x", last_x, 6);
    chk("basic_done_after_ack", done_cyc, last_ack + 1);

    pass(4, 3, 0, 4, 2, 2, 1, 1, 1, 1'b0);
    check_pass("bp");

    pass(4, 2, 3, 7, 2, 5, 0, 0, 0, 1'b0);
    check_pass("early");
    chk("early_last_ack", last_ack, 3);
    chk("early_done_cyc", done_cyc, 7);

    clr();
    set_cfg(0, 5, 1, 1, 1, 1);
    u.start = 1'b1; drive(0, 0, 0, 3); tick();
    u.start = 1'b0; tick(); tick();
    chk("illw_err", err_cnt, 1);
    chk("illw_err_cyc", err_cyc, 1);
    chk("illw_busy", busy_hi, 0);
    chk("illw_setinfo", set_cnt, 0);
    chk("illw_cfgW", int'(u.config_W), exp_w);
    chk("illw_cfgqpus", cfg_out(), exp_cfg);
    clr();
    set_cfg(7, 0, 0, 0, 0, 0);
    u.start = 1'b1; tick();
    u.start = 1'b0; tick(); tick();
    chk("illf_err", err_cnt, 1);
    chk("illf_busy", busy_hi, 0);
    chk("illf_setinfo", set_cnt, 0);
    chk("illf_cfgF", int'(u.config_F), exp_f);

    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(8'($urandom));
    clr();
    cur_f = 4;
    set_cfg(8, 4, 1, 1, 1, 1);
    u.start = 1'b1;
    for (int n = 0; n < 40 && got.size() < 3; n++) begin
      drive(8, 0, 0, 3);
      tick();
      u.start = 1'b0;
    end
    rst = 1'b1; u.src_valid = 1'b0;
    tick();
    rst = 1'b0; u.src_valid = 1'b1; u.opsum_enable = 1'b1;
    chk("rst_mid_xfers", got.size(), 3);
    outs_zero("rst_mid_outs");
    chk("rst_mid_cfgW", int'(u.config_W), 0);
    tick(); tick();
    chk("rst_mid_nodone", done_cnt, 0);
    u.opsum_enable = 1'b0;
    pass(2, 1, 2, 3, 4, 5, 0, 0, 2, 1'b0);
    check_pass("after_rst");

    pass(6, 2, 1, 17, 3, 3, 0, 1, 1, 1'b1);
    check_pass("busy_start");

    for (int k = 0; k < 6; k++)
      pass($urandom_range(1, 24), $urandom_range(1, 8), $urandom_range(0, 3),
           $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 15),
           2, 1, 1, 1'b0);
    check_pass("rand");

    pass(4095, 5, 3, 31, 15, 15, 0, 0, 1, 1'b0);
    check_pass("w4095");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
